// File: rtl/rv_decode_stage.sv
// RV32I/RV64I decode stage: registers decoded fields, immediate, operand flags and
// illegal flag behind a valid/ready stream with a 2-entry skid, flush and illegal counter.
module rv_decode_stage #(
  parameter int unsigned XLEN          = 32,
  parameter bit          ENABLE_SYSTEM = 1'b1,
  parameter int unsigned ID_WIDTH      = 4,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_inst,
  input  logic [XLEN-1:0]      in_pc,
  input  logic [ID_WIDTH-1:0]  in_id,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_pc,
  output logic [ID_WIDTH-1:0]  out_id,
  output logic [6:0]           out_opcode,
  output logic [4:0]           out_rd,
  output logic [4:0]           out_rs1,
  output logic [4:0]           out_rs2,
  output logic [2:0]           out_funct3,
  output logic [6:0]           out_funct7,
  output logic [11:0]          out_funct12,
  output logic [XLEN-1:0]      out_imm,
  output logic                 out_uses_rs1,
  output logic                 out_uses_rs2,
  output logic                 out_writes_rd,
  output logic                 out_illegal,
  output logic [CNT_WIDTH-1:0] illegal_count
);

  localparam bit IS_RV64 = (XLEN == 64);

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_FENCE  = 7'h0F;
  localparam logic [6:0] OPC_IMM    = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_IMM32  = 7'h1B;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_OP32   = 7'h3B;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  typedef struct packed {
    logic [XLEN-1:0]     pc;
    logic [ID_WIDTH-1:0] id;
    logic [6:0]          opcode;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic [11:0]         funct12;
    logic [XLEN-1:0]     imm;
    logic                uses_rs1;
    logic                uses_rs2;
    logic                writes_rd;
    logic                illegal;
  } beat_t;

  beat_t dec;
  beat_t out_q, out_d;
  beat_t skid_q, skid_d;
  logic  out_valid_q, out_valid_d;
  logic  skid_valid_q, skid_valid_d;
  logic  in_ready_q, in_ready_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm32;
  logic        legal_opc;
  logic        fld_ok;
  logic        use1, use2, wr_rd;
  logic        in_fire, out_fire, drain;

  // Combinational decode of the incoming word
  always_comb begin
    dec       = '0;
    opc       = in_inst[6:0];
    f3        = in_inst[14:12];
    f7        = in_inst[31:25];
    imm32     = {{20{in_inst[31]}}, in_inst[31:20]};
    legal_opc = 1'b1;
    fld_ok    = 1'b1;
    use1      = 1'b0;
    use2      = 1'b0;
    wr_rd     = 1'b0;

    case (opc)
      OPC_LOAD: begin
        use1   = 1'b1;
        wr_rd  = 1'b1;
        fld_ok = IS_RV64 ? (f3 != 3'd7) : !((f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7));
      end
      OPC_STORE: begin
        imm32  = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
        use1   = 1'b1;
        use2   = 1'b1;
        fld_ok = IS_RV64 ? (f3 <= 3'd3) : (f3 <= 3'd2);
      end
      OPC_BRANCH: begin
        imm32  = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                  in_inst[11:8], 1'b0};
        use1   = 1'b1;
        use2   = 1'b1;
        fld_ok = (f3 != 3'd2) && (f3 != 3'd3);
      end
      OPC_JALR: begin
        use1   = 1'b1;
        wr_rd  = 1'b1;
        fld_ok = (f3 == 3'd0);
      end
      OPC_JAL: begin
        imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                 in_inst[30:21], 1'b0};
        wr_rd = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm32 = {in_inst[31:12], 12'h000};
        wr_rd = 1'b1;
      end
      OPC_OP: begin
        use1   = 1'b1;
        use2   = 1'b1;
        wr_rd  = 1'b1;
        fld_ok = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
      end
      OPC_IMM: begin
        use1  = 1'b1;
        wr_rd = 1'b1;
        // Shift-immediates: shamt is 5 bits on RV32, 6 bits on RV64
        case (f3)
          3'd1: fld_ok = IS_RV64 ? (in_inst[31:26] == 6'h00) : (f7 == 7'h00);
          3'd5: fld_ok = IS_RV64 ? ((in_inst[31:26] == 6'h00) || (in_inst[31:26] == 6'h10))
                                 : ((f7 == 7'h00) || (f7 == 7'h20));
          default: fld_ok = 1'b1;
        endcase
      end
      OPC_OP32: begin
        legal_opc = IS_RV64;
        use1      = 1'b1;
        use2      = 1'b1;
        wr_rd     = 1'b1;
      end
      OPC_IMM32: begin
        legal_opc = IS_RV64;
        use1      = 1'b1;
        wr_rd     = 1'b1;
      end
      OPC_SYSTEM: begin
        legal_opc = ENABLE_SYSTEM;
        use1      = (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd3);
        wr_rd     = (f3 != 3'd0);
      end
      OPC_FENCE: begin
        legal_opc = ENABLE_SYSTEM;
      end
      default: legal_opc = 1'b0;
    endcase

    dec.pc        = in_pc;
    dec.id        = in_id;
    dec.opcode    = opc;
    dec.rd        = in_inst[11:7];
    dec.rs1       = in_inst[19:15];
    dec.rs2       = in_inst[24:20];
    dec.funct3    = f3;
    dec.funct7    = f7;
    dec.funct12   = in_inst[31:20];
    dec.imm       = XLEN'($signed(imm32));
    dec.illegal   = (in_inst[1:0] != 2'b11) || !legal_opc || !fld_ok;
    dec.uses_rs1  = use1 && !dec.illegal;
    dec.uses_rs2  = use2 && !dec.illegal;
    dec.writes_rd = wr_rd && (in_inst[11:7] != 5'd0) && !dec.illegal;
  end

  // Output register + skid steering, flush and illegal counter
  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    cnt_d        = cnt_q;
    in_fire      = in_valid && in_ready_q && !flush;
    out_fire     = out_valid_q && out_ready;
    drain        = !out_valid_q || out_ready;

    if (out_fire && out_q.illegal && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end

    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (drain) begin
      // in_ready is low whenever skid holds a beat, so skid and input never compete
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end

    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      cnt_q        <= '0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      cnt_q        <= cnt_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign out_valid     = out_valid_q;
  assign out_pc        = out_q.pc;
  assign out_id        = out_q.id;
  assign out_opcode    = out_q.opcode;
  assign out_rd        = out_q.rd;
  assign out_rs1       = out_q.rs1;
  assign out_rs2       = out_q.rs2;
  assign out_funct3    = out_q.funct3;
  assign out_funct7    = out_q.funct7;
  assign out_funct12   = out_q.funct12;
  assign out_imm       = out_q.imm;
  assign out_uses_rs1  = out_q.uses_rs1;
  assign out_uses_rs2  = out_q.uses_rs2;
  assign out_writes_rd = out_q.writes_rd;
  assign out_illegal   = out_q.illegal;
  assign illegal_count = cnt_q;

endmodule
